// File: rtl/pattern_seq_pkg.sv
// Shared types and defaults for the pattern sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pattern_seq_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_FWD  = 2'b01,
    MODE_REV  = 2'b10,
    MODE_PING = 2'b11
  } mode_e;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_PRE_W = 24;

endpackage

// File: rtl/seq_prescaler.sv
// Prescaler: emits one tick every period+1 cycles while run is high.
// Latency: tick is combinational from the registered count (same cycle).
// Backpressure: none; run low freezes the count without clearing it.
module seq_prescaler
  import pattern_seq_pkg::*;
#(
  parameter int PRE_W = DEF_PRE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [PRE_W-1:0] period,
  output logic             tick
);

  logic [PRE_W-1:0] count;

  // A tick fires only on an exact match; an overshoot (period lowered) just reloads.
  assign tick = run && (count == period);

  // Count up while running, reload on match or overshoot, hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (run) begin
      if (count >= period) begin
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pattern_sequencer.sv
// Pattern sequencer: writable word bank stepped by an internal index in hold/fwd/rev/ping-pong.
// Latency: contador, S and wrap all update on the edge after a tick/step/clamp; loads bypass to S.
// Backpressure: none; loads and steps are always accepted.
module pattern_sequencer
  import pattern_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int IDX_W = $clog2(DEPTH),
  parameter int PRE_W = DEF_PRE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_en,
  input  logic [IDX_W-1:0] load_addr,
  input  logic [WIDTH-1:0] load_data,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic             step,
  input  logic [PRE_W-1:0] period,
  input  logic [IDX_W-1:0] last_idx,
  output logic [WIDTH-1:0] S,
  output logic [IDX_W-1:0] contador,
  output logic             wrap
);

  logic [WIDTH-1:0] bank [DEPTH];
  logic [IDX_W-1:0] contador_next;
  logic             wrap_next;
  logic             dir_up;
  logic             dir_up_next;
  logic             tick;
  logic             run;
  logic             at_last;
  logic             at_zero;
  logic             go_up;
  mode_e            mode_sel;

  assign mode_sel = mode_e'(mode);
  assign run      = enable && (mode_sel != MODE_HOLD);

  seq_prescaler #(
    .PRE_W (PRE_W)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .run    (run),
    .period (period),
    .tick   (tick)
  );

  // Next index, wrap pulse and ping-pong direction; clamp beats everything else.
  always_comb begin
    contador_next = contador;
    wrap_next     = 1'b0;
    // Direction is parked at "up" outside ping-pong so entering it always starts upward.
    dir_up_next   = (mode_sel == MODE_PING) ? dir_up : 1'b1;
    at_last       = (contador == last_idx);
    at_zero       = (contador == '0);
    go_up         = 1'b1;

    if (contador > last_idx) begin
      contador_next = '0;
    end else if (mode_sel == MODE_HOLD) begin
      if (step) begin
        contador_next = at_last ? '0 : contador + 1'b1;
        wrap_next     = at_last;
      end
    end else if (tick) begin
      case (mode_sel)
        MODE_FWD: begin
          contador_next = at_last ? '0 : contador + 1'b1;
          wrap_next     = at_last;
        end
        MODE_REV: begin
          contador_next = at_zero ? last_idx : contador - 1'b1;
          wrap_next     = at_zero;
        end
        MODE_PING: begin
          if (last_idx == '0) begin
            // Single-entry range: nowhere to move, every tick is a reversal.
            wrap_next   = 1'b1;
            dir_up_next = 1'b1;
          end else begin
            // Sitting on the far endpoint (after a mode entry or clamp) turns us around.
            go_up         = dir_up ? !at_last : at_zero;
            contador_next = go_up ? contador + 1'b1 : contador - 1'b1;
            dir_up_next   = go_up;
            if (go_up && (contador_next == last_idx)) begin
              dir_up_next = 1'b0;
              wrap_next   = 1'b1;
            end else if (!go_up && (contador_next == '0)) begin
              dir_up_next = 1'b1;
              wrap_next   = 1'b1;
            end
          end
        end
        MODE_HOLD: begin
        end
      endcase
    end
  end

  // Index, direction and wrap registers, plus the displayed word with write-first bypass.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      contador <= '0;
      wrap     <= 1'b0;
      dir_up   <= 1'b1;
      S        <= '0;
    end else begin
      contador <= contador_next;
      wrap     <= wrap_next;
      dir_up   <= dir_up_next;
      if (load_en && (load_addr == contador_next)) begin
        S <= load_data;
      end else begin
        S <= bank[contador_next];
      end
    end
  end

  // Pattern bank writes; contents are cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        bank[i] <= '0;
      end
    end else if (load_en) begin
      bank[load_addr] <= load_data;
    end
  end

endmodule

// File: tb/tb_pattern_sequencer.sv
// Bench for pattern_sequencer: directed scenarios plus randomized traffic vs a behavioural model.
// Latency: model predicts the post-edge state; outputs are compared on every falling edge.
// Backpressure: n/a.
module tb_pattern_sequencer;

  localparam int W  = 16;
  localparam int D  = 8;
  localparam int IW = 3;
  localparam int PW = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          load_en = 1'b0;
  logic [IW-1:0] load_addr = '0;
  logic [W-1:0]  load_data = '0;
  logic          enable = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic          step = 1'b0;
  logic [PW-1:0] period = '0;
  logic [IW-1:0] last_idx = '0;
  logic [W-1:0]  S;
  logic [IW-1:0] contador;
  logic          wrap;

  int vectors     = 0;
  int miscompares = 0;
  bit checking    = 1'b0;

  int pp_c[7] = '{1, 2, 3, 2, 1, 0, 1};
  int pp_w[7] = '{0, 0, 1, 0, 0, 1, 0};

  pattern_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .enable    (enable),
    .mode      (mode),
    .step      (step),
    .period    (period),
    .last_idx  (last_idx),
    .S         (S),
    .contador  (contador),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  // Behavioural model: plain integers for position, prescale count and direction.
  logic [W-1:0] m_bank [D];
  int           m_c   = 0;
  int           m_cnt = 0;
  logic [W-1:0] m_s   = '0;
  bit           m_wrap = 1'b0;
  bit           m_up   = 1'b1;
  int           ml, mc;
  bit           mtick, mw, mup;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < D; i++) m_bank[i] = '0;
      m_c = 0; m_cnt = 0; m_s = '0; m_wrap = 1'b0; m_up = 1'b1;
    end else begin
      mtick = 1'b0;
      if (enable && mode != 2'b00) begin
        if (m_cnt == int'(period)) begin mtick = 1'b1; m_cnt = 0; end
        else if (m_cnt > int'(period)) m_cnt = 0;
        else m_cnt = m_cnt + 1;
      end
      ml = int'(last_idx); mc = m_c; mw = 1'b0; mup = m_up;
      if (mc > ml) begin
        mc = 0;
      end else if (mode == 2'b00) begin
        if (step) begin mw = (mc == ml); mc = mw ? 0 : mc + 1; end
      end else if (mtick) begin
        if (mode == 2'b01) begin
          mw = (mc == ml); mc = mw ? 0 : mc + 1;
        end else if (mode == 2'b10) begin
          mw = (mc == 0); mc = mw ? ml : mc - 1;
        end else if (ml == 0) begin
          mw = 1'b1; mup = 1'b1;
        end else begin
          if (mup && mc == ml) mup = 1'b0;
          else if (!mup && mc == 0) mup = 1'b1;
          mc = mup ? mc + 1 : mc - 1;
          if (mc == ml || mc == 0) begin mw = 1'b1; mup = !mup; end
        end
      end
      if (mode != 2'b11) mup = 1'b1;
      if (load_en) m_bank[load_addr] = load_data;
      m_c = mc; m_up = mup; m_wrap = mw; m_s = m_bank[mc];
    end
  end

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (checking && !rst) begin
      vectors++;
      if (contador !== m_c[IW-1:0]) begin
        miscompares++;
        $display("FAIL model_contador t=%0t: got %0d expected %0d", $time, contador, m_c);
      end
      vectors++;
      if (S !== m_s) begin
        miscompares++;
        $display("FAIL model_S t=%0t: got %h expected %h", $time, S, m_s);
      end
      vectors++;
      if (wrap !== m_wrap) begin
        miscompares++;
        $display("FAIL model_wrap t=%0t: got %b expected %b", $time, wrap, m_wrap);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_ramp();
    for (int i = 0; i < D; i++) begin
      load_en   = 1'b1;
      load_addr = IW'(i);
      load_data = W'(16'h0101 * (i + 1));
      cyc();
    end
    load_en = 1'b0;
  endtask

  initial begin
    #2 rst = 1'b1;
    #1;
    chk("rst_contador", 32'(contador), 32'd0);
    chk("rst_S", 32'(S), 32'd0);
    chk("rst_wrap", 32'(wrap), 32'd0);
    cyc(2);
    rst = 1'b0;
    checking = 1'b1;

    // Fill the bank, then run forward at full rate.
    load_ramp();
    chk("load_bypass_S", 32'(S), 32'h0101);
    last_idx = 3'd7; period = '0; mode = 2'b01; enable = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cyc();
      chk("fwd_S", 32'(S), 32'(16'h0101 * (((k + 1) % 8) + 1)));
      chk("fwd_wrap", 32'(wrap), 32'(k == 7));
    end

    // period=3: one step per 4 cycles; a 2-cycle enable drop delays it by 2.
    period = PW'(3);
    cyc(3); chk("pre_hold", 32'(contador), 32'd0);
    cyc();  chk("pre_tick", 32'(contador), 32'd1);
    cyc();
    enable = 1'b0; cyc(2);
    enable = 1'b1; cyc(2);
    chk("freeze_hold", 32'(contador), 32'd1);
    cyc();  chk("freeze_tick", 32'(contador), 32'd2);

    // Ping-pong over 0..3 starting from 0.
    mode = 2'b00; last_idx = 3'd0; cyc();
    chk("clamp_to_zero", 32'(contador), 32'd0);
    period = '0; last_idx = 3'd3; mode = 2'b11;
    for (int k = 0; k < 7; k++) begin
      cyc();
      chk("ping_contador", 32'(contador), 32'(pp_c[k]));
      chk("ping_wrap", 32'(wrap), 32'(pp_w[k]));
    end

    // Reverse over 0..5, then clamp by lowering last_idx.
    mode = 2'b00; last_idx = 3'd0; cyc();
    mode = 2'b10; last_idx = 3'd5;
    cyc(); chk("rev_contador0", 32'(contador), 32'd5); chk("rev_wrap0", 32'(wrap), 32'd1);
    cyc(); chk("rev_contador1", 32'(contador), 32'd4); chk("rev_wrap1", 32'(wrap), 32'd0);
    last_idx = 3'd2;
    cyc(); chk("rev_clamp", 32'(contador), 32'd0); chk("rev_clamp_wrap", 32'(wrap), 32'd0);

    // Hold: only step pulses move the index.
    mode = 2'b00; last_idx = 3'd7; step = 1'b1;
    cyc(); chk("hold_step1", 32'(contador), 32'd1);
    cyc(); chk("hold_step2", 32'(contador), 32'd2);
    cyc(); chk("hold_step3", 32'(contador), 32'd3);
    step = 1'b0;
    for (int k = 0; k < 6; k++) begin
      enable = ~enable;
      period = PW'(k);
      cyc();
    end
    chk("hold_still", 32'(contador), 32'd3);

    // Randomized traffic, checked every cycle against the model.
    for (int n = 0; n < 4000; n++) begin
      load_en   = ($urandom_range(9) == 0);
      load_addr = IW'($urandom_range(D - 1));
      load_data = W'($urandom);
      if ($urandom_range(15) == 0) mode = 2'($urandom_range(3));
      enable = ($urandom_range(4) != 0);
      step   = ($urandom_range(2) == 0);
      if ($urandom_range(7) == 0) period = PW'($urandom_range(4));
      if ($urandom_range(19) == 0) last_idx = IW'($urandom_range(D - 1));
      cyc();
    end

    // Asynchronous reset mid-operation.
    load_en = 1'b0; mode = 2'b00; enable = 1'b0; step = 1'b0;
    load_ramp();
    last_idx = 3'd0; cyc();
    last_idx = 3'd7; step = 1'b1; cyc(6); step = 1'b0;
    chk("pre_rst_contador", 32'(contador), 32'd6);
    chk("pre_rst_S", 32'(S), 32'h0707);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_contador", 32'(contador), 32'd0);
    chk("async_rst_S", 32'(S), 32'd0);
    chk("async_rst_wrap", 32'(wrap), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step = 1'b1; cyc(); step = 1'b0;
    chk("post_rst_contador", 32'(contador), 32'd1);
    chk("post_rst_bank", 32'(S), 32'd0);
    load_en = 1'b1; load_addr = 3'd1; load_data = 16'hBEEF;
    cyc();
    load_en = 1'b0;
    chk("bypass_S", 32'(S), 32'h0000BEEF);
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pattern_sequencer.md
Name: pattern_sequencer

Overview:
Parametrised successor to the 8-word, 16-bit pattern selector. It holds its own writable bank of DEPTH pattern words and its own index counter, so callers no longer supply an external select. A prescaled tick steps the index in hold, forward, reverse or ping-pong mode over a programmable active length. It feeds the display/output stage with one registered pattern word per step.

Parameters:
WIDTH, 16, bits per pattern word
DEPTH, 8, number of pattern words (power of two, >=2)
IDX_W, $clog2(DEPTH), index width (derived, not overridden)
PRE_W, 24, prescaler/period width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
load_en  input  1  write load_data into bank[load_addr] this cycle
load_addr  input  IDX_W  bank write address
load_data  input  WIDTH  bank write data
enable  input  1  prescaler and auto-stepping run when 1
mode  input  2  00 hold, 01 forward, 10 reverse, 11 ping-pong
step  input  1  single-step pulse, honoured only in hold mode
period  input  PRE_W  step every period+1 cycles
last_idx  input  IDX_W  highest active index (active length = last_idx+1)
S  output  WIDTH  registered pattern word = bank[contador]
contador  output  IDX_W  current index
wrap  output  1  one-cycle pulse when the sequence wraps or reverses

Behaviour:
- One clock domain (clk). Reset is asynchronous, active-high (rst).
- Reset values:
  - all bank words 0
  - contador 0, S 0, wrap 0
  - prescaler count 0
  - ping-pong direction = up
- Prescaler:
  - Counts only while enable=1 and mode!=00.
  - When count==period, it asserts an internal tick and reloads count to 0; otherwise count increments.
  - period=0 gives a tick every cycle.
  - enable=0 freezes the count. It does not clear it.
  - Changing period while count>period: the next cycle reloads count to 0 with no tick.
- Index update on tick:
  - Forward: contador==last_idx -> 0 with wrap=1; else +1.
  - Reverse: contador==0 -> last_idx with wrap=1; else -1.
  - Ping-pong: moves in the current direction. Reaching last_idx (up) or 0 (down) flips the direction and pulses wrap. The endpoint is shown once, not repeated.
  - Ping-pong with last_idx=0: contador stays 0; wrap pulses on every tick.
- Hold (mode 00):
  - The prescaler is idle.
  - step=1 advances one position, forward semantics, including wrap.
  - step is ignored in every other mode.
- Clamp:
  - If contador>last_idx (last_idx lowered at runtime), contador goes to 0 on the next cycle regardless of tick. wrap is not pulsed.
- Mode change:
  - Takes effect on the next tick. Index is preserved.
  - Entering ping-pong sets direction=up.
- Output:
  - S is registered each cycle as S <= bank[contador_next], so S and contador change on the same edge.
- Load:
  - The write takes effect at the edge.
  - If load_addr equals the index being displayed next cycle, S shows load_data on that same edge (write-first bypass).
  - Load never affects contador or the prescaler.
- Simultaneous tick and step: step is ignored unless mode=00 (no tick in hold), so there is no conflict.
- Reset mid-operation: everything returns to reset values immediately (asynchronous). Bank contents are lost.
- wrap is high for exactly one cycle, aligned with the edge on which contador takes its wrapped value.

Decomposition:
- Package pattern_seq_pkg holds:
  - mode enum: MODE_HOLD=2'b00, MODE_FWD=2'b01, MODE_REV=2'b10, MODE_PING=2'b11
  - default WIDTH/DEPTH constants
- One natural sub-module: seq_prescaler (count, period compare, tick out, enable/freeze).
- The bank and index logic stay in the top module.

Test Plan:
- Reset, then load bank[i]=16'h0101*(i+1) for i=0..7; mode=01, period=0, last_idx=7, enable=1 -> S steps 0101,0202,…,0808,0101. wrap pulses on the 0808->0101 edge.
- mode=01, period=3 -> contador advances every 4 cycles. Drop enable for 2 cycles mid-count -> the next step is delayed by exactly 2 cycles.
- mode=11, last_idx=3, period=0 -> contador 0,1,2,3,2,1,0,1. wrap pulses when entering 3 and when entering 0.
- mode=10, last_idx=5, from contador=0 -> next value 5 with wrap=1, then 4. Lower last_idx to 2 while contador=4 -> contador=0 next cycle, no wrap.
- mode=00: three step pulses -> contador 0->1->2->3. Toggle enable and period -> no movement without step.
- Assert rst while contador=6, S=16'h0707 -> contador=0, S=0, wrap=0 immediately. Bank reads 0 after release. load_en to the displayed index -> S updates on the same edge.
